mem_arbiter: RTL

//  Shares the single multi-cycle main memory between I-cache fill, D-cache fill and D-side

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Main-memory arbiter shared by I-cache fill, D-cache fill and write-through stores.
// Block fills issue one read per cycle; returned words are registered before the cache write.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 4,
    parameter int unsigned WORDS   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_miss,
    input  logic [15:0]                i_addr,
    input  logic                       d_miss,
    input  logic [15:0]                d_addr,
    input  logic                       d_wr_req,
    input  logic [15:0]                d_wr_data,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [15:0]                mem_addr,
    output logic [15:0]                mem_wdata,
    input  logic [15:0]                mem_rdata,
    input  logic                       mem_data_valid,
    output logic [15:0]                fill_data,
    output logic [$clog2(WORDS)-1:0]   fill_word,
    output logic                       i_fill_we,
    output logic                       d_fill_we,
    output logic                       i_fill_done,
    output logic                       d_fill_done,
    output logic                       d_wr_done,
    output logic                       stall_fetch,
    output logic                       stall_mem
);

    localparam int unsigned WW = $clog2(WORDS);
    localparam int unsigned IW = WW + 1;
    localparam int unsigned LW = $clog2(MEM_LAT) + 1;
    localparam logic [15:0] BLK_MASK = 16'(2 * WORDS - 1);

    typedef enum logic [2:0] {StIdle, StDFill, StIFill, StDWrite, StWaitWr} state_e;

    state_e          state_q, state_d;
    logic [15:0]     base_q, base_d;
    logic [IW-1:0]   ic_q, ic_d;
    logic [WW-1:0]   rc_q, rc_d;
    logic [LW-1:0]   wc_q, wc_d;
    logic [15:0]     fill_data_q, fill_data_d;
    logic [WW-1:0]   fill_word_q, fill_word_d;
    logic            fill_we_q, fill_we_d;
    logic            done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            ic_q        <= '0;
            rc_q        <= '0;
            wc_q        <= '0;
            fill_data_q <= '0;
            fill_word_q <= '0;
            fill_we_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            ic_q        <= ic_d;
            rc_q        <= rc_d;
            wc_q        <= wc_d;
            fill_data_q <= fill_data_d;
            fill_word_q <= fill_word_d;
            fill_we_q   <= fill_we_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        ic_d        = ic_q;
        rc_d        = rc_q;
        wc_d        = wc_q;
        fill_data_d = fill_data_q;
        fill_word_d = fill_word_q;
        fill_we_d   = 1'b0;
        done_d      = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        d_wr_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ic_d = '0;
                rc_d = '0;
                wc_d = '0;
                // Stores first: the MEM-stage instruction is older than the fetch.
                if (d_wr_req) begin
                    state_d = StDWrite;
                end else if (d_miss) begin
                    state_d = StDFill;
                    base_d  = d_addr & ~BLK_MASK;
                end else if (i_miss) begin
                    state_d = StIFill;
                    base_d  = i_addr & ~BLK_MASK;
                end
            end
            StDFill, StIFill: begin
                if (ic_q < IW'(WORDS)) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + {{(15 - IW){1'b0}}, ic_q, 1'b0};
                    ic_d     = ic_q + IW'(1);
                end
                if (mem_data_valid) begin
                    fill_we_d   = 1'b1;
                    fill_data_d = mem_rdata;
                    fill_word_d = rc_q;
                    rc_d        = rc_q + WW'(1);
                end
                if (fill_we_q && fill_word_q == WW'(WORDS - 1)) begin
                    done_d = 1'b1;
                end
                // Leaving on the done cycle keeps a stale request from being re-granted.
                if (done_q) begin
                    state_d = StIdle;
                end
            end
            StDWrite: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wr_data;
                state_d   = StWaitWr;
            end
            StWaitWr: begin
                if (wc_q == LW'(MEM_LAT - 1)) begin
                    d_wr_done = 1'b1;
                    state_d   = StIdle;
                end else begin
                    wc_d = wc_q + LW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fill_data   = fill_data_q;
    assign fill_word   = fill_word_q;
    assign i_fill_we   = fill_we_q & (state_q == StIFill);
    assign d_fill_we   = fill_we_q & (state_q == StDFill);
    assign i_fill_done = done_q & (state_q == StIFill);
    assign d_fill_done = done_q & (state_q == StDFill);
    assign stall_fetch = i_miss & ~i_fill_done;
    assign stall_mem   = (d_miss & ~d_fill_done) | (d_wr_req & ~d_wr_done);

endmodule
